// File: rtl/pps_cs_tick_gen_if.sv
// Bundle of the PPS inputs and the timebase outputs of pps_cs_tick_gen.
//   pps       PPS input (asynchronous), rising edge marks a second boundary
//   pps_en    1 = discipline divider phase to PPS, 0 = free-run
//   cs_tick   one-cycle pulse per centisecond
//   sec_tick  one-cycle pulse per second, always coincident with cs_tick
//   cs_phase  current centisecond index within the second
//   locked    high while the divider is locked to PPS
//   pps_err   one-cycle pulse on a rejected PPS edge
// master: drives pps/pps_en (stimulus or system side); slave: the tick generator.
interface pps_cs_tick_gen_if;
  logic       pps;
  logic       pps_en;
  logic       cs_tick;
  logic       sec_tick;
  logic [6:0] cs_phase;
  logic       locked;
  logic       pps_err;

  modport master (
    output pps, pps_en,
    input  cs_tick, sec_tick, cs_phase, locked, pps_err
  );

  modport slave (
    input  pps, pps_en,
    output cs_tick, sec_tick, cs_phase, locked, pps_err
  );
endinterface

// File: rtl/pps_cs_tick_gen.sv
// Centisecond timebase for the binary clock. Divides clk by DIV into a one-cycle
// cs_tick, counts CS_PER_S ticks per second into cs_phase and pulses sec_tick on the
// wrap. With pps_en set, the divider phase is disciplined to an external 1 Hz PPS
// pulse: edges inside +/-TOL centiseconds of the boundary realign the divider,
// LOCK_N consecutive good edges give lock, an out-of-window edge while locked is
// rejected with pps_err, and MISS_S seconds without an edge drop back to UNLOCKED.
// Ports:
//   clk  system clock (posedge)
//   rst  synchronous active-high reset
//   bus  pps_cs_tick_gen_if.slave (pps, pps_en in; cs_tick, sec_tick, cs_phase,
//        locked, pps_err out)
module pps_cs_tick_gen #(
  parameter int DIV      = 100,
  parameter int CS_PER_S = 100,
  parameter int TOL      = 2,
  parameter int LOCK_N   = 3,
  parameter int MISS_S   = 2
) (
  input logic              clk,
  input logic              rst,
  pps_cs_tick_gen_if.slave bus
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW = $clog2(LOCK_N + 1);
  localparam int MW = $clog2(MISS_S + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [6:0]    PH_LAST   = 7'(CS_PER_S - 1);
  localparam logic [6:0]    WIN_HI    = 7'(CS_PER_S - TOL);
  localparam logic [6:0]    WIN_LO    = 7'(TOL);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_N - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(MISS_S - 1);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [GW-1:0] good;
  logic [MW-1:0] miss;

  logic          pps_p0, pps_p1, pps_p2;
  logic          cs_tick_p0, sec_tick_p0, locked_p0, pps_err_p0;
  logic [6:0]    cs_phase_p0;

  logic          pps_edge, cs_wrap, sec_wrap, early, in_win, miss_out;

  assign pps_edge = pps_p1 & ~pps_p2;
  assign cs_wrap  = (div_cnt == DIV_LAST);
  assign sec_wrap = cs_wrap && (cs_phase_p0 == PH_LAST);
  // Early side of the window: this second's sec_tick has not been emitted yet,
  // so an aligning edge must emit it.
  assign early    = (cs_phase_p0 >= WIN_HI);
  assign in_win   = early || (cs_phase_p0 < WIN_LO);
  assign miss_out = sec_wrap && (miss >= MISS_LAST);

  assign bus.cs_tick  = cs_tick_p0;
  assign bus.sec_tick = sec_tick_p0;
  assign bus.cs_phase = cs_phase_p0;
  assign bus.locked   = locked_p0;
  assign bus.pps_err  = pps_err_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pps_p0      <= 1'b0;
      pps_p1      <= 1'b0;
      pps_p2      <= 1'b0;
      div_cnt     <= '0;
      cs_phase_p0 <= '0;
      cs_tick_p0  <= 1'b0;
      sec_tick_p0 <= 1'b0;
      locked_p0   <= 1'b0;
      pps_err_p0  <= 1'b0;
      good        <= '0;
      miss        <= '0;
      state       <= UNLOCKED;
    end else begin
      // Stage p0..p2: PPS synchroniser pair plus history flop for edge detect
      pps_p0 <= bus.pps;
      pps_p1 <= pps_p0;
      pps_p2 <= pps_p1;

      // Stage p0 outputs: free-running divider; alignment below overrides it
      div_cnt     <= cs_wrap ? '0 : div_cnt + 1'b1;
      cs_tick_p0  <= cs_wrap;
      sec_tick_p0 <= sec_wrap;
      if (cs_wrap)
        cs_phase_p0 <= sec_wrap ? '0 : cs_phase_p0 + 7'd1;
      pps_err_p0  <= 1'b0;

      if (!bus.pps_en) begin
        state     <= UNLOCKED;
        good      <= '0;
        miss      <= '0;
        locked_p0 <= 1'b0;
      end else begin
        case (state)
          UNLOCKED: begin
            locked_p0 <= 1'b0;
            if (pps_edge) begin
              // First edge sets the phase blindly; no boundary to honour yet.
              div_cnt     <= '0;
              cs_phase_p0 <= '0;
              cs_tick_p0  <= 1'b0;
              sec_tick_p0 <= 1'b0;
              good        <= GW'(1);
              miss        <= '0;
              state       <= ACQUIRE;
            end
          end
          ACQUIRE: begin
            locked_p0 <= 1'b0;
            if (pps_edge) begin
              div_cnt     <= '0;
              cs_phase_p0 <= '0;
              cs_tick_p0  <= early;
              sec_tick_p0 <= early;
              miss        <= '0;
              if (in_win) begin
                if (good >= GOOD_LAST) begin
                  good      <= GW'(LOCK_N);
                  state     <= LOCKED;
                  locked_p0 <= 1'b1;
                end else begin
                  good <= good + 1'b1;
                end
              end else begin
                good       <= GW'(1);
                pps_err_p0 <= 1'b1;
              end
            end else if (miss_out) begin
              miss  <= '0;
              good  <= '0;
              state <= UNLOCKED;
            end else if (sec_wrap) begin
              miss <= miss + 1'b1;
            end
          end
          LOCKED: begin
            locked_p0 <= 1'b1;
            if (pps_edge) begin
              miss <= '0;
              if (in_win) begin
                div_cnt     <= '0;
                cs_phase_p0 <= '0;
                cs_tick_p0  <= early;
                sec_tick_p0 <= early;
              end else begin
                // A stray edge while locked is distrusted: keep phase, re-acquire.
                pps_err_p0 <= 1'b1;
                good       <= '0;
                state      <= ACQUIRE;
                locked_p0  <= 1'b0;
              end
            end else if (miss_out) begin
              miss      <= '0;
              good      <= '0;
              state     <= UNLOCKED;
              locked_p0 <= 1'b0;
            end else if (sec_wrap) begin
              miss <= miss + 1'b1;
            end
          end
          default: begin
            state     <= UNLOCKED;
            locked_p0 <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pps_cs_tick_gen.sv
// Testbench for pps_cs_tick_gen with DIV=4, CS_PER_S=10, TOL=2, LOCK_N=3, MISS_S=2.
// A reference model tracks the divider as "cycles since the last alignment point"
// and derives cs_tick/cs_phase/sec_tick arithmetically, plus the lock rules.
module tb_pps_cs_tick_gen;
  localparam int DIV    = 4;
  localparam int CS     = 10;
  localparam int TOL    = 2;
  localparam int LOCK_N = 3;
  localparam int MISS_S = 2;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic pps    = 1'b0;
  logic pps_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  pps_cs_tick_gen_if bus ();
  assign bus.pps    = pps;
  assign bus.pps_en = pps_en;

  pps_cs_tick_gen #(
    .DIV(DIV), .CS_PER_S(CS), .TOL(TOL), .LOCK_N(LOCK_N), .MISS_S(MISS_S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: state after each posedge.
  int cyc = 0, anchor = 0, m_state = 0, m_good = 0, m_miss = 0, e_ph = 0;
  int k, ph_now;
  bit e_cs, e_sec, e_lock, e_err;
  bit sh0, sh1, sh2, m_edge, m_early, m_win, nat_sec, do_align, pulse;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      anchor = cyc;
      sh0 = 0; sh1 = 0; sh2 = 0;
      m_state = 0; m_good = 0; m_miss = 0;
      e_cs = 0; e_sec = 0; e_ph = 0; e_lock = 0; e_err = 0;
    end else begin
      ph_now  = ((cyc - 1 - anchor) / DIV) % CS;
      m_edge  = sh1 & ~sh2;
      sh2 = sh1; sh1 = sh0; sh0 = pps;
      k       = cyc - anchor;
      e_cs    = (k % DIV == 0);
      e_ph    = (k / DIV) % CS;
      e_sec   = e_cs && (e_ph == 0);
      nat_sec = e_sec;
      e_err   = 0;
      m_early = (ph_now >= CS - TOL);
      m_win   = m_early || (ph_now < TOL);
      do_align = 0; pulse = 0;
      if (!pps_en) begin
        m_state = 0; m_good = 0; m_miss = 0;
      end else if (m_state == 0) begin
        if (m_edge) begin do_align = 1; m_good = 1; m_miss = 0; m_state = 1; end
      end else begin
        if (m_edge) begin
          m_miss = 0;
          if (m_win) begin
            do_align = 1; pulse = m_early;
            if (m_state == 1) begin
              m_good++;
              if (m_good >= LOCK_N) m_state = 2;
            end
          end else if (m_state == 1) begin
            do_align = 1; m_good = 1; e_err = 1;
          end else begin
            e_err = 1; m_good = 0; m_state = 1;
          end
        end else if (nat_sec) begin
          m_miss++;
          if (m_miss >= MISS_S) begin m_state = 0; m_good = 0; m_miss = 0; end
        end
      end
      if (do_align) begin
        anchor = cyc;
        e_cs = pulse; e_sec = pulse; e_ph = 0;
      end
      e_lock = (m_state == 2);
    end
  end

  logic [10:0] obs, expv;
  assign obs  = {bus.cs_tick, bus.sec_tick, bus.cs_phase, bus.locked, bus.pps_err};
  assign expv = {e_cs, e_sec, 7'(e_ph), e_lock, e_err};

  task automatic step(input logic p);
    pps = p;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; pps_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      n_checks++;
      if (obs !== 11'd0) begin
        n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, 11'd0);
      end
    end
    rst = 1'b0;
    // PPS held high through reset gives one edge; it realigns, so first tick moves to cycle 7.
    for (int i = 0; i < 12; i++) begin
      step(i < 6);
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL reset_release_model i=%0d: got %h expected %h", i, obs, expv);
      end
      n_checks++;
      if (bus.cs_tick !== 1'((i == 6) || (i == 10))) begin
        n_fail++; $display("FAIL reset_pps_high_tick i=%0d: got %b", i, bus.cs_tick);
      end
    end
  endtask

  task automatic test_free_run();
    pps_en = 1'b0; rst = 1'b1; step(1'b0); rst = 1'b0;
    for (int n = 1; n <= 120; n++) begin
      step(1'($urandom_range(0, 1)));
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL free_run_model n=%0d: got %h expected %h", n, obs, expv);
      end
      n_checks++;
      if (bus.cs_tick !== 1'(n % 4 == 0) || bus.sec_tick !== 1'(n % 40 == 0) ||
          bus.cs_phase !== 7'((n / 4) % 10)) begin
        n_fail++; $display("FAIL free_run_timing n=%0d: got tick=%b sec=%b ph=%0d",
                           n, bus.cs_tick, bus.sec_tick, bus.cs_phase);
      end
    end
  endtask

  task automatic test_lock();
    int off, w, lock_at, errs;
    rst = 1'b1; pps_en = 1'b1; step(1'b0); rst = 1'b0;
    off = $urandom_range(0, 39); w = $urandom_range(1, 3);
    lock_at = -1; errs = 0;
    for (int t = 0; t < off + 200; t++) begin
      step((t >= off) && ((t - off) % 40 < w));
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL lock_model t=%0d: got %h expected %h", t, obs, expv);
      end
      if (bus.pps_err === 1'b1) errs++;
      if (bus.locked === 1'b1 && lock_at < 0) lock_at = t;
    end
    n_checks++;
    if (lock_at != off + 82) begin
      n_fail++; $display("FAIL lock_rise_time: got %0d expected %0d", lock_at, off + 82);
    end
    n_checks++;
    if (errs != 0 || bus.locked !== 1'b1) begin
      n_fail++; $display("FAIL lock_final: errs=%0d locked=%b expected 0/1", errs, bus.locked);
    end
  endtask

  task automatic test_early_late();
    int segs[4] = '{40, 38, 46, 40};
    int t, w, secs, errs;
    t = 0; secs = 0; errs = 0; w = $urandom_range(1, 3);
    foreach (segs[j]) begin
      for (int i = 0; i < segs[j]; i++) begin
        step(i < w);
        n_checks++;
        if (obs !== expv) begin
          n_fail++; $display("FAIL early_late_model t=%0d: got %h expected %h", t, obs, expv);
        end
        if (bus.sec_tick === 1'b1) secs++;
        if (bus.pps_err === 1'b1) errs++;
        if (t == 80) begin
          n_checks++;
          if (bus.sec_tick !== 1'b1 || bus.cs_phase !== 7'd0) begin
            n_fail++; $display("FAIL early_edge: got sec=%b ph=%0d expected 1/0", bus.sec_tick, bus.cs_phase);
          end
        end
        if (t == 126) begin
          n_checks++;
          if (bus.sec_tick !== 1'b0 || bus.cs_phase !== 7'd0) begin
            n_fail++; $display("FAIL late_edge: got sec=%b ph=%0d expected 0/0", bus.sec_tick, bus.cs_phase);
          end
        end
        t++;
      end
    end
    n_checks++;
    if (secs != 4 || errs != 0 || bus.locked !== 1'b1) begin
      n_fail++; $display("FAIL early_late_summary: secs=%0d errs=%0d locked=%b expected 4/0/1",
                         secs, errs, bus.locked);
    end
  endtask

  task automatic test_bad_edge();
    int segs[6] = '{40, 22, 18, 40, 40, 40};
    int t, w, errs;
    t = 0; errs = 0; w = $urandom_range(1, 3);
    foreach (segs[j]) begin
      for (int i = 0; i < segs[j]; i++) begin
        step(i < w);
        n_checks++;
        if (obs !== expv) begin
          n_fail++; $display("FAIL bad_edge_model t=%0d: got %h expected %h", t, obs, expv);
        end
        if (bus.pps_err === 1'b1) errs++;
        if (t == 64) begin
          n_checks++;
          if (bus.pps_err !== 1'b1 || bus.locked !== 1'b0 || bus.cs_phase !== 7'd5) begin
            n_fail++; $display("FAIL bad_edge_reject: got err=%b locked=%b ph=%0d expected 1/0/5",
                               bus.pps_err, bus.locked, bus.cs_phase);
          end
        end
        t++;
      end
    end
    n_checks++;
    if (errs != 1 || bus.locked !== 1'b1) begin
      n_fail++; $display("FAIL bad_edge_summary: errs=%0d locked=%b expected 1/1", errs, bus.locked);
    end
  endtask

  task automatic test_pps_loss();
    int last_cs, secs;
    bit fell;
    last_cs = -1; secs = 0; fell = 0;
    for (int t = 0; t < 80; t++) begin
      step(1'b0);
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL pps_loss_model t=%0d: got %h expected %h", t, obs, expv);
      end
      if (bus.cs_tick === 1'b1) begin
        if (last_cs >= 0) begin
          n_checks++;
          if (t - last_cs != 4) begin
            n_fail++; $display("FAIL pps_loss_tick_gap: got %0d expected 4", t - last_cs);
          end
        end
        last_cs = t;
      end
      if (bus.sec_tick === 1'b1) secs++;
      if (!fell && bus.locked === 1'b0) begin
        fell = 1;
        n_checks++;
        if (secs != 2 || bus.sec_tick !== 1'b1) begin
          n_fail++; $display("FAIL pps_loss_drop: got secs=%0d sec=%b expected 2/1", secs, bus.sec_tick);
        end
      end
    end
    n_checks++;
    if (!fell) begin
      n_fail++; $display("FAIL pps_loss_timeout: locked=%b expected 0", bus.locked);
    end
  endtask

  task automatic test_reset_mid();
    int w, extra;
    w = $urandom_range(1, 3);
    for (int t = 0; t < 160; t++) begin
      step((t % 40) < w);
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL reset_mid_model t=%0d: got %h expected %h", t, obs, expv);
      end
    end
    n_checks++;
    if (bus.locked !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_prelock: got %b expected 1", bus.locked);
    end
    extra = $urandom_range(5, 30);
    for (int t = 0; t < extra; t++) step(1'b0);
    rst = 1'b1; step(1'b0);
    n_checks++;
    if (obs !== 11'd0) begin
      n_fail++; $display("FAIL reset_mid_clear: got %h expected %h", obs, 11'd0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0);
      n_checks++;
      if (obs !== expv || bus.cs_tick !== 1'(i % 4 == 0) || bus.locked !== 1'b0) begin
        n_fail++; $display("FAIL reset_mid_restart i=%0d: got %h expected %h", i, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_lock();
    test_early_late();
    test_bad_edge();
    test_pps_loss();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
